// File: rtl/uart_alu_intf_ctrl.sv
// Frame controller: pops A, B, opcode from the UART RX buffer,
// runs the ALU and pushes one result byte to the UART TX buffer.
module uart_alu_intf_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_empty,
  input  logic [NB_DATA-1:0] rx_data,
  output logic               rx_rd,
  output logic [NB_DATA-1:0] alu_data_a,
  output logic [NB_DATA-1:0] alu_data_b,
  output logic [NB_OP-1:0]   alu_op,
  input  logic [NB_DATA-1:0] alu_result,
  input  logic               tx_full,
  output logic               tx_wr,
  output logic [NB_DATA-1:0] tx_data,
  output logic               busy,
  output logic               frame_err
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW =
    TO_EN ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ?
             $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
  localparam logic [CW-1:0] TERM =
    CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TO_EN ? TIMEOUT_CYCLES : 0);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          in_rx;
  logic          waiting;
  logic          pop;
  logic          push;
  logic          tmo;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    in_rx     = (state == WAIT_A) ||
                (state == WAIT_B) ||
                (state == WAIT_OP);
    waiting   = (state == WAIT_B) ||
                (state == WAIT_OP);
    pop       = in_rx && !rx_empty;
    push      = (state == SEND) && !tx_full;
    tmo       = TO_EN && waiting && rx_empty &&
                (cnt == TERM);

    case (state)
      WAIT_A:  if (pop) state_nxt = WAIT_B;
      WAIT_B:  if (pop) state_nxt = WAIT_OP;
               else if (tmo) state_nxt = WAIT_A;
      WAIT_OP: if (pop) state_nxt = EXEC;
               else if (tmo) state_nxt = WAIT_A;
      EXEC:    state_nxt = SEND;
      SEND:    if (push) state_nxt = WAIT_A;
      default: state_nxt = WAIT_A;
    endcase

    // Idle-gap counter: saturates, never wraps
    if (!TO_EN || pop || state_nxt == WAIT_A)
      cnt_nxt = '0;
    else if (waiting && rx_empty && cnt != CNT_MAX)
      cnt_nxt = cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= WAIT_A;
      cnt        <= '0;
      alu_data_a <= '0;
      alu_data_b <= '0;
      alu_op     <= '0;
      tx_data    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pop && state == WAIT_A)
        alu_data_a <= rx_data;
      if (pop && state == WAIT_B)
        alu_data_b <= rx_data;
      if (pop && state == WAIT_OP)
        alu_op <= rx_data[NB_OP-1:0];
      if (state == EXEC)
        tx_data <= alu_result;
    end
  end

  assign rx_rd     = reset && pop;
  assign tx_wr     = reset && push;
  assign frame_err = reset && tmo;
  assign busy      = (state != WAIT_A);

endmodule
